// File: rtl/sam_con_stream.sv
// Streaming 1-D convolution of signed samples against a serially loaded ternary kernel,
// with valid/ready input, strided output decimation and an optional zero-padded flush tail.
module sam_con_stream #(
    parameter int DATA_W      = 32,
    parameter int KERNEL_SIZE = 8,
    parameter int STRIDE      = 1,
    parameter int PAD_MODE    = 0,
    parameter int OUT_W       = DATA_W + $clog2(KERNEL_SIZE) + 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Kernel_Load_En,
    input  logic [1:0]               Kernel_Serial_Input,
    input  logic                     Data_In_Valid,
    output logic                     Data_In_Ready,
    input  logic signed [DATA_W-1:0] Data_In,
    input  logic                     Last_Data_In,
    output logic                     Data_Out_Valid,
    output logic signed [OUT_W-1:0]  Data_Out,
    output logic                     Last_Data_Out
);

    localparam int FILL_W = $clog2(KERNEL_SIZE + 1);
    localparam int PH_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int FL_W   = $clog2(KERNEL_SIZE);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                    state_reg, state_next;
    logic [1:0]                kernel_reg [KERNEL_SIZE];
    logic signed [DATA_W-1:0]  window_reg [KERNEL_SIZE];
    logic [FILL_W-1:0]         fill_reg;
    logic [PH_W-1:0]           phase_reg;
    logic [FL_W-1:0]           flush_reg;
    logic                      valid_reg, last_reg;
    logic signed [OUT_W-1:0]   data_reg;

    logic                      accept, inject, shift_en, kernel_load;
    logic                      complete, emit, final_pos;
    logic signed [DATA_W-1:0]  sample_in;
    logic signed [DATA_W-1:0]  shifted [KERNEL_SIZE];
    logic signed [OUT_W-1:0]   term    [KERNEL_SIZE];
    logic signed [OUT_W-1:0]   sum;

    assign Data_In_Ready  = Rst_n && (state_reg != FLUSH);
    assign accept         = Data_In_Valid && Data_In_Ready;
    assign inject         = (state_reg == FLUSH);
    assign shift_en       = accept || inject;
    assign sample_in      = inject ? '0 : Data_In;
    // A valid sample in IDLE takes priority over a kernel load request.
    assign kernel_load    = (state_reg == IDLE) && !Data_In_Valid && Kernel_Load_En;
    assign complete       = fill_reg >= FILL_W'(KERNEL_SIZE - 1);
    assign emit           = shift_en && complete && (phase_reg == '0);
    assign final_pos      = (accept && Last_Data_In && (PAD_MODE == 0)) ||
                            (inject && (flush_reg == FL_W'(KERNEL_SIZE - 2)));

    // The window as it will look after this cycle's shift; the result is taken from it.
    generate
        for (genvar gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_shift
            assign shifted[gi] = window_reg[gi+1];
        end
    endgenerate
    assign shifted[KERNEL_SIZE-1] = sample_in;

    generate
        for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_term
            logic signed [OUT_W-1:0] ext;
            assign ext      = {{(OUT_W-DATA_W){shifted[gi][DATA_W-1]}}, shifted[gi]};
            assign term[gi] = (kernel_reg[gi] == 2'b01) ? ext :
                              (kernel_reg[gi] == 2'b11) ? -ext : '0;
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int j = 0; j < KERNEL_SIZE; j++) begin
            sum = sum + term[j];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, RUN: begin
                if (accept) begin
                    if (Last_Data_In) begin
                        state_next = (PAD_MODE != 0) ? FLUSH : IDLE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            FLUSH: begin
                if (flush_reg == FL_W'(KERNEL_SIZE - 2)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= IDLE;
            fill_reg  <= '0;
            phase_reg <= '0;
            flush_reg <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            data_reg  <= '0;
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                kernel_reg[j] <= 2'b00;
                window_reg[j] <= '0;
            end
        end else begin
            state_reg <= state_next;
            valid_reg <= emit;
            last_reg  <= final_pos;
            if (emit) begin
                data_reg <= sum;
            end
            if (kernel_load) begin
                for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                    kernel_reg[j] <= kernel_reg[j+1];
                end
                kernel_reg[KERNEL_SIZE-1] <= Kernel_Serial_Input;
            end
            if (final_pos) begin
                fill_reg  <= '0;
                phase_reg <= '0;
                flush_reg <= '0;
                for (int j = 0; j < KERNEL_SIZE; j++) begin
                    window_reg[j] <= '0;
                end
            end else if (shift_en) begin
                for (int j = 0; j < KERNEL_SIZE; j++) begin
                    window_reg[j] <= shifted[j];
                end
                if (fill_reg != FILL_W'(KERNEL_SIZE)) begin
                    fill_reg <= fill_reg + 1'b1;
                end
                if (complete) begin
                    phase_reg <= (phase_reg == PH_W'(STRIDE - 1)) ? '0 : phase_reg + 1'b1;
                end
                if (inject) begin
                    flush_reg <= flush_reg + 1'b1;
                end
            end
        end
    end

    assign Data_Out_Valid = valid_reg;
    assign Data_Out       = data_reg;
    assign Last_Data_Out  = last_reg;

endmodule

// File: tb/tb_sam_con_stream.sv
// Directed bench for sam_con_stream: K=8 stride 1 and 2 engines sharing stimulus,
// plus a K=4 zero-padded engine for the flush tail.
module tb_sam_con_stream;

    logic Clk, Rst_n;

    logic               kld, vld, lst;
    logic [1:0]         kcode;
    logic signed [31:0] din;
    logic               rdy_a, dv_a, dl_a, rdy_b, dv_b, dl_b;
    logic signed [35:0] do_a, do_b;

    logic               kld_p, vld_p, lst_p;
    logic [1:0]         kcode_p;
    logic signed [31:0] din_p;
    logic               rdy_p, dv_p, dl_p;
    logic signed [34:0] do_p;

    int total = 0;
    int bad   = 0;

    sam_con_stream #(.DATA_W(32), .KERNEL_SIZE(8), .STRIDE(1), .PAD_MODE(0)) u_a (
        .Clk(Clk), .Rst_n(Rst_n), .Kernel_Load_En(kld), .Kernel_Serial_Input(kcode),
        .Data_In_Valid(vld), .Data_In_Ready(rdy_a), .Data_In(din), .Last_Data_In(lst),
        .Data_Out_Valid(dv_a), .Data_Out(do_a), .Last_Data_Out(dl_a));

    sam_con_stream #(.DATA_W(32), .KERNEL_SIZE(8), .STRIDE(2), .PAD_MODE(0)) u_b (
        .Clk(Clk), .Rst_n(Rst_n), .Kernel_Load_En(kld), .Kernel_Serial_Input(kcode),
        .Data_In_Valid(vld), .Data_In_Ready(rdy_b), .Data_In(din), .Last_Data_In(lst),
        .Data_Out_Valid(dv_b), .Data_Out(do_b), .Last_Data_Out(dl_b));

    sam_con_stream #(.DATA_W(32), .KERNEL_SIZE(4), .STRIDE(1), .PAD_MODE(1)) u_p (
        .Clk(Clk), .Rst_n(Rst_n), .Kernel_Load_En(kld_p), .Kernel_Serial_Input(kcode_p),
        .Data_In_Valid(vld_p), .Data_In_Ready(rdy_p), .Data_In(din_p), .Last_Data_In(lst_p),
        .Data_Out_Valid(dv_p), .Data_Out(do_p), .Last_Data_Out(dl_p));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic               kld;
        logic [1:0]         kc;
        logic signed [31:0] din;
        logic               lst;
        logic               ev_a;
        logic signed [35:0] ed_a;
        logic               el_a;
        logic               ev_b;
        logic signed [35:0] ed_b;
        logic               el_b;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic k, input logic [1:0] kc, input logic signed [31:0] d,
                                input logic l, input logic eva, input logic signed [35:0] eda,
                                input logic ela, input logic evb, input logic signed [35:0] edb,
                                input logic elb);
        vec_t v;
        v.kld = k;   v.kc = kc;   v.din = d;    v.lst = l;
        v.ev_a = eva; v.ed_a = eda; v.el_a = ela;
        v.ev_b = evb; v.ed_b = edb; v.el_b = elb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // mode 0: codes 00,01,00,01,...  mode 1: all 11
    task automatic load_ab(input int mode);
        vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            kld   = 1'b1;
            kcode = (mode == 1) ? 2'b11 : ((i % 2 == 1) ? 2'b01 : 2'b00);
            tick();
        end
        kld = 1'b0;
    endtask

    task automatic apply_tbl(input int first, input int n, input string tag);
        for (int i = first; i < first + n; i++) begin
            kld = tbl[i].kld; kcode = tbl[i].kc; vld = 1'b1; din = tbl[i].din; lst = tbl[i].lst;
            tick();
            chk({tag, " a_valid"}, dv_a, tbl[i].ev_a);
            if (tbl[i].ev_a) chk({tag, " a_data"}, do_a, tbl[i].ed_a);
            chk({tag, " a_last"}, dl_a, tbl[i].el_a);
            chk({tag, " b_valid"}, dv_b, tbl[i].ev_b);
            if (tbl[i].ev_b) chk({tag, " b_data"}, do_b, tbl[i].ed_b);
            chk({tag, " b_last"}, dl_b, tbl[i].el_b);
            $display("%s vec %0d din=%0d a=%0b/%0d/%0b b=%0b/%0d/%0b", tag, i, tbl[i].din,
                     dv_a, do_a, dl_a, dv_b, do_b, dl_b);
        end
        kld = 1'b0; vld = 1'b0; lst = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0;
        kld = 0; kcode = 0; vld = 0; din = 0; lst = 0;
        kld_p = 0; kcode_p = 0; vld_p = 0; din_p = 0; lst_p = 0;

        // seg1 [0..15]: alternating kernel, data 0..15; load request on first beat must be ignored
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(i == 0, 2'b11, 32'(i), i == 15, i >= 7, 36'(16 + 4 * (i - 7)), i == 15,
                             (i >= 7) && ((i - 7) % 2 == 0), 36'(16 + 4 * (i - 7)), i == 15));
        // seg2 [16..23]: all -1 kernel, data 1..8
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1'b0, 2'b00, 32'(i), i == 8, i == 8, -36'sd36, i == 8,
                             i == 8, -36'sd36, i == 8));
        // seg3 [24..31]: most negative sample x8 against all -1 kernel
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b0, 2'b00, 32'sh8000_0000, i == 7, i == 7, 36'sd17179869184, i == 7,
                             i == 7, 36'sd17179869184, i == 7));
        // seg4 [32..34]: short stream, only the last marker
        for (int i = 5; i <= 7; i++)
            tbl.push_back(mk(1'b0, 2'b00, 32'(i), i == 7, 1'b0, 36'sd0, i == 7, 1'b0, 36'sd0, i == 7));

        #3;
        chk("rst a_valid", dv_a, 0);
        chk("rst a_data", do_a, 0);
        chk("rst a_last", dl_a, 0);
        chk("rst p_valid", dv_p, 0);
        #19 Rst_n = 1'b1;
        tick();
        chk("rel a_ready", rdy_a, 1);
        chk("rel p_ready", rdy_p, 1);

        load_ab(0);
        apply_tbl(0, 16, "s1");
        load_ab(1);
        apply_tbl(16, 8, "neg");
        apply_tbl(24, 8, "min");
        apply_tbl(32, 3, "short");

        // K=4 padded flush
        for (int i = 0; i < 4; i++) begin
            kld_p = 1'b1; kcode_p = 2'b01;
            tick();
        end
        kld_p = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            vld_p = 1'b1; din_p = 32'(i); lst_p = (i == 3);
            tick();
            chk("pad valid_fill", dv_p, 0);
            $display("pad beat %0d ready=%0b valid=%0b last=%0b", i, rdy_p, dv_p, dl_p);
        end
        din_p = 32'sd99; lst_p = 1'b0;
        begin
            logic signed [34:0] exp_p [3];
            exp_p[0] = 35'sd6; exp_p[1] = 35'sd5; exp_p[2] = 35'sd3;
            chk("pad ready_flush", rdy_p, 0);
            for (int i = 0; i < 3; i++) begin
                if (i == 2) vld_p = 1'b0;
                tick();
                chk("pad valid", dv_p, 1);
                chk("pad data", do_p, exp_p[i]);
                chk("pad last", dl_p, i == 2);
                chk("pad ready", rdy_p, i == 2);
                $display("pad flush %0d data=%0d last=%0b ready=%0b", i, do_p, dl_p, rdy_p);
            end
        end
        tick();
        chk("pad last_clear", dl_p, 0);

        // gaps and kernel load attempts during RUN on the alternating kernel
        load_ab(0);
        for (int i = 0; i < 16; i++) begin
            int gaps;
            gaps = (i > 0) ? $urandom_range(0, 3) : 0;
            for (int g = 0; g < gaps; g++) begin
                vld = 1'b0; kld = 1'b1; kcode = 2'b11; din = 32'($urandom);
                tick();
                chk("gap a_valid", dv_a, 0);
                chk("gap b_valid", dv_b, 0);
            end
            vld = 1'b1; din = 32'(i); lst = (i == 15);
            kld = (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0; kcode = 2'b11;
            tick();
            chk("gap a_beat_valid", dv_a, i >= 7);
            if (i >= 7) chk("gap a_data", do_a, 16 + 4 * (i - 7));
            chk("gap a_last", dl_a, i == 15);
            chk("gap b_beat_valid", dv_b, (i >= 7) && ((i - 7) % 2 == 0));
            $display("gap beat %0d gaps=%0d a=%0b/%0d/%0b", i, gaps, dv_a, do_a, dl_a);
        end
        vld = 1'b0; kld = 1'b0; lst = 1'b0;

        // asynchronous reset mid-stream
        for (int i = 1; i <= 5; i++) begin
            vld = 1'b1; din = 32'(i); lst = 1'b0;
            vld_p = 1'b1; din_p = 32'(10 * i); lst_p = 1'b0;
            tick();
        end
        chk("pre_rst p_data", do_p, 140);
        chk("pre_rst p_valid", dv_p, 1);
        #3 Rst_n = 1'b0;
        #1;
        chk("arst p_valid", dv_p, 0);
        chk("arst p_data", do_p, 0);
        chk("arst a_data", do_a, 0);
        chk("arst a_last", dl_a, 0);
        vld = 1'b0; vld_p = 1'b0;
        @(posedge Clk);
        #3 Rst_n = 1'b1;
        tick();
        chk("post_rst a_ready", rdy_a, 1);
        chk("post_rst a_last", dl_a, 0);
        chk("post_rst p_last", dl_p, 0);

        // cleared kernel: a full window produces zero
        for (int i = 1; i <= 8; i++) begin
            vld = 1'b1; din = 32'(i * 7); lst = (i == 8);
            tick();
        end
        vld = 1'b0; lst = 1'b0;
        chk("zk a_valid", dv_a, 1);
        chk("zk a_data", do_a, 0);
        chk("zk a_last", dl_a, 1);

        load_ab(0);
        apply_tbl(0, 16, "again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
